hashtable_request_issuer: RTL and testbench
===========================================

HASHTABLE_REQUEST_ISSUER -- requirements
Module: hashtable_request_issuer

Interface
REQ-001 Parameters SHALL be: KEY_WIDTH, default 32, key bits; DATA_WIDTH, default 32, value bits; FIFO_DEPTH, default 4 (power of two, at least 2), request buffer entries; MAX_OUTSTANDING, default 8, ops allowed in flight.
REQ-002 Clocking SHALL be one clock; reset is synchronous and active-high.
REQ-003 Ports SHALL be listed in this order.
  clk_i  in  1  clock
  reset_i  in  1  synchronous active-high reset
  req_valid_i  in  1  host request valid
  req_ready_o  out  1  host request ready
  req_op_i  in  2  00 nothing, 01 read, 10 write, 11 delete
  req_key_i  in  KEY_WIDTH  request key
  req_data_i  in  DATA_WIDTH  write value (ignored for read/delete)
  stall_i  in  1  pipeline cannot take an op this cycle
  resp_done_i  in  1  pipeline retired one op this cycle
  delete_write_read_o  out  2  op code to pipeline, 00 = nothing
  key_o  out  KEY_WIDTH  op key
  data_o  out  DATA_WIDTH  op value
  outstanding_o  out  clog2(MAX_OUTSTANDING+1)  ops in flight
  idle_o  out  1  FIFO empty and outstanding_o == 0
  error_o  out  1  sticky: resp_done_i seen with nothing in flight

Function
REQ-004 Host handshake: a request SHALL be accepted on a rising edge where req_valid_i and req_ready_o are both 1.
REQ-005 req_ready_o SHALL equal NOT fifo_full; it SHALL NOT depend combinationally on req_valid_i or on a same-cycle pop.
REQ-006 An accepted request with req_op_i == 00 SHALL be discarded and not enqueued; op codes 01/10/11 SHALL be enqueued as {op, key, data}.
REQ-007 The FIFO SHALL be in-order with wrap-around pointers; push and pop on the same edge SHALL leave the occupancy unchanged.
REQ-008 Issue condition (evaluated combinationally): FIFO not empty AND outstanding < MAX_OUTSTANDING AND stall_i == 0.
REQ-009 On an edge where the issue condition holds, the FIFO head SHALL pop and delete_write_read_o/key_o/data_o SHALL register its op/key/data.
REQ-010 On any other edge, delete_write_read_o SHALL register 00; key_o/data_o SHALL hold their previous values.
REQ-011 Latency: a request accepted at edge k into an empty FIFO, with credits available and no stall, SHALL appear on delete_write_read_o after edge k+1; the sustained rate SHALL be one op per cycle.
REQ-012 Outstanding counter: +1 on issue, -1 on resp_done_i, unchanged when both occur on the same edge.
REQ-013 The issue condition SHALL use the pre-edge count; a response on the same edge SHALL NOT unblock an issue at MAX_OUTSTANDING.
REQ-014 resp_done_i with outstanding == 0 and no same-edge issue SHALL leave the counter at 0 (no underflow) and set error_o.
REQ-015 error_o SHALL remain set until reset.
REQ-016 idle_o SHALL be derived combinationally from registered state.

Reset
REQ-017 While reset_i is high at an edge, every register SHALL clear: FIFO empty, pointers 0, outstanding_o=0, delete_write_read_o=00, key_o=0, data_o=0, error_o=0.
REQ-018 Reset values: req_ready_o=1 and idle_o=1.
REQ-019 Reset asserted mid-operation SHALL discard buffered requests and the in-flight count.
REQ-020 A handshake on a reset edge SHALL NOT be enqueued.

Verification
REQ-021 Single write: key 0x5, data 0xA5 accepted at edge 0 -> after edge 1, delete_write_read_o=10, key_o=0x5, data_o=0xA5, outstanding_o=1; after edge 2, op=00.
REQ-022 Back-pressure: stall_i=1, 5 requests offered back-to-back -> 4 accepted, req_ready_o=0; release stall -> 4 ops issued on consecutive cycles in order; ready returns 1 after the first pop.
REQ-023 Credit limit: 10 reads, no responses -> exactly 8 issued, outstanding_o=8; one resp_done_i -> 9th read issued on the following edge, not the same edge.
REQ-024 Simultaneous issue and resp_done_i at outstanding=3 -> stays 3; resp_done_i at outstanding=0 -> error_o=1 and held, count stays 0.
REQ-025 req_op_i=00 with valid -> accepted, nothing issued, idle_o stays 1; reset with 3 buffered and 2 outstanding -> all outputs return to reset values next cycle.

Source files
------------

// File: rtl/hashtable_request_issuer.sv
// Buffers host hashtable requests (read/write/delete) and issues them to the lookup pipeline, limited by an outstanding-op credit count.
// Latency: a request accepted at edge k into an empty buffer is presented on delete_write_read_o after edge k+1; one op per cycle sustained.
// Backpressure: req_ready_o drops only when the buffer is full; issue holds off on stall_i or when MAX_OUTSTANDING ops are in flight.
module hashtable_request_issuer #(
  parameter int KEY_WIDTH       = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic                                 req_valid_i,
  output logic                                 req_ready_o,
  input  logic [1:0]                           req_op_i,
  input  logic [KEY_WIDTH-1:0]                 req_key_i,
  input  logic [DATA_WIDTH-1:0]                req_data_i,
  input  logic                                 stall_i,
  input  logic                                 resp_done_i,
  output logic [1:0]                           delete_write_read_o,
  output logic [KEY_WIDTH-1:0]                 key_o,
  output logic [DATA_WIDTH-1:0]                data_o,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding_o,
  output logic                                 idle_o,
  output logic                                 error_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);

  typedef struct packed {
    logic [1:0]            op;
    logic [KEY_WIDTH-1:0]  key;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  entry_t           mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [OCC_W-1:0] occ;

  logic             push;
  logic             issue;
  logic [CNT_W-1:0] cnt_next;
  logic             err_set;
  entry_t           head;

  // Ready depends only on registered occupancy, never on valid or a same-cycle pop.
  assign req_ready_o = (occ != OCC_FULL);
  assign head        = mem[rd_ptr];

  // Op code 00 is a no-op: it completes the handshake but never occupies a slot.
  assign push  = req_valid_i && req_ready_o && (req_op_i != 2'b00);
  // Credit check uses the pre-edge count, so a same-edge response cannot unblock a full window.
  assign issue = (occ != '0) && (outstanding_o < CNT_MAX) && !stall_i;

  assign idle_o = (occ == '0) && (outstanding_o == '0);

  // Request buffer: storage, wrap-around pointers and occupancy.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{op: req_op_i, key: req_key_i, data: req_data_i};
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (issue) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, issue})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  // Outstanding count update; a response with nothing in flight flags an error instead of underflowing.
  always_comb begin
    cnt_next = outstanding_o;
    err_set  = 1'b0;
    case ({issue, resp_done_i})
      2'b10: cnt_next = outstanding_o + CNT_W'(1);
      2'b01: begin
        if (outstanding_o == '0) err_set = 1'b1;
        else                     cnt_next = outstanding_o - CNT_W'(1);
      end
      default: cnt_next = outstanding_o;
    endcase
  end

  // Registered pipeline outputs, credit counter and sticky error flag.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      delete_write_read_o <= 2'b00;
      key_o               <= '0;
      data_o              <= '0;
      outstanding_o       <= '0;
      error_o             <= 1'b0;
    end else begin
      outstanding_o <= cnt_next;
      if (err_set) error_o <= 1'b1;
      if (issue) begin
        delete_write_read_o <= head.op;
        key_o               <= head.key;
        data_o              <= head.data;
      end else begin
        delete_write_read_o <= 2'b00;
      end
    end
  end

endmodule

// File: tb/tb_hashtable_request_issuer.sv
// Bench for hashtable_request_issuer: scoreboard of issued ops plus directed state checks.
// Latency and ordering are checked against hand-computed expectations.
// Stimulus is driven 1 time unit after each rising edge; ops are popped and compared on the falling edge.
module tb_hashtable_request_issuer;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [1:0]  req_op_i;
  logic [31:0] req_key_i;
  logic [31:0] req_data_i;
  logic        stall_i;
  logic        resp_done_i;
  logic [1:0]  delete_write_read_o;
  logic [31:0] key_o;
  logic [31:0] data_o;
  logic [3:0]  outstanding_o;
  logic        idle_o;
  logic        error_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] key;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];

  hashtable_request_issuer #(
    .KEY_WIDTH(32), .DATA_WIDTH(32), .FIFO_DEPTH(4), .MAX_OUTSTANDING(8)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_op_i(req_op_i), .req_key_i(req_key_i), .req_data_i(req_data_i),
    .stall_i(stall_i), .resp_done_i(resp_done_i),
    .delete_write_read_o(delete_write_read_o), .key_o(key_o), .data_o(data_o),
    .outstanding_o(outstanding_o), .idle_o(idle_o), .error_o(error_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Offer one request, holding valid until the handshake completes (bounded).
  task automatic send(input logic [1:0] op, input logic [31:0] k, input logic [31:0] d);
    int  n;
    bit  done;
    exp_t e;
    n    = 0;
    done = 1'b0;
    if (op != 2'b00) begin
      e.op = op; e.key = k; e.data = d;
      exp_q.push_back(e);
    end
    req_valid_i = 1'b1;
    req_op_i    = op;
    req_key_i   = k;
    req_data_i  = d;
    while (!done && n < 64) begin
      if (req_ready_o) done = 1'b1;
      tick();
      n++;
    end
    req_valid_i = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: key 0x%0h not accepted within 64 cycles", k);
    end
  endtask

  // Scoreboard monitor: every issued op must match the oldest expected op.
  always @(negedge clk_i) begin
    if (delete_write_read_o != 2'b00) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: op %0b key 0x%0h data 0x%0h with nothing expected",
                 delete_write_read_o, key_o, data_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (delete_write_read_o !== e.op || key_o !== e.key || data_o !== e.data) begin
          errors++;
          $display("FAIL sb_op: got op %0b key 0x%0h data 0x%0h, expected op %0b key 0x%0h data 0x%0h",
                   delete_write_read_o, key_o, data_o, e.op, e.key, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    reset_i = 1'b1; req_valid_i = 1'b0; req_op_i = 2'b00; req_key_i = '0; req_data_i = '0;
    stall_i = 1'b0; resp_done_i = 1'b0;
    tick(); tick();

    // Reset state
    check("rst_ready", req_ready_o, 1);
    check("rst_idle", idle_o, 1);
    check("rst_outstanding", outstanding_o, 0);
    check("rst_op", delete_write_read_o, 0);
    check("rst_key", key_o, 0);
    check("rst_data", data_o, 0);
    check("rst_error", error_o, 0);
    reset_i = 1'b0;
    tick();

    // Single write: accepted at edge 0, issued after edge 1, gone after edge 2
    e.op = 2'b10; e.key = 32'h5; e.data = 32'hA5;
    exp_q.push_back(e);
    req_valid_i = 1'b1; req_op_i = 2'b10; req_key_i = 32'h5; req_data_i = 32'hA5;
    tick();
    req_valid_i = 1'b0;
    check("wr_edge0_op", delete_write_read_o, 0);
    tick();
    check("wr_edge1_op", delete_write_read_o, 2'b10);
    check("wr_edge1_key", key_o, 32'h5);
    check("wr_edge1_data", data_o, 32'hA5);
    check("wr_edge1_outstanding", outstanding_o, 1);
    tick();
    check("wr_edge2_op", delete_write_read_o, 0);
    check("wr_edge2_key_hold", key_o, 32'h5);
    resp_done_i = 1'b1; tick(); resp_done_i = 1'b0;
    check("wr_drain_outstanding", outstanding_o, 0);

    // Back-pressure: stalled pipeline, 5 offered, first 4 fit
    stall_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      req_valid_i = 1'b1; req_op_i = 2'b01; req_key_i = 32'h10 + i; req_data_i = 32'h100 + i;
      check("bp_ready", req_ready_o, (i < 4) ? 1 : 0);
      if (i < 4) begin
        e.op = 2'b01; e.key = 32'h10 + i; e.data = 32'h100 + i;
        exp_q.push_back(e);
      end
      tick();
    end
    req_valid_i = 1'b0;
    check("bp_full_ready", req_ready_o, 0);
    check("bp_stalled_op", delete_write_read_o, 0);
    stall_i = 1'b0;
    tick();
    check("bp_ready_after_pop", req_ready_o, 1);
    check("bp_first_key", key_o, 32'h10);
    for (int j = 1; j < 4; j++) begin
      tick();
      check("bp_consec_op", delete_write_read_o, 2'b01);
      check("bp_consec_key", key_o, 32'h10 + j);
    end
    tick();
    check("bp_done_op", delete_write_read_o, 0);
    check("bp_outstanding", outstanding_o, 4);
    resp_done_i = 1'b1;
    repeat (4) tick();
    resp_done_i = 1'b0;
    check("bp_drain", outstanding_o, 0);

    // Credit limit: 10 reads, no responses
    for (int i = 0; i < 10; i++) send(2'b01, 32'h20 + i, 32'h200 + i);
    repeat (3) tick();
    check("cr_outstanding_max", outstanding_o, 8);
    check("cr_blocked_op", delete_write_read_o, 0);
    check("cr_not_idle", idle_o, 0);
    resp_done_i = 1'b1; tick(); resp_done_i = 1'b0;
    check("cr_no_same_edge_issue", delete_write_read_o, 0);
    check("cr_after_resp", outstanding_o, 7);
    tick();
    check("cr_9th_op", delete_write_read_o, 2'b01);
    check("cr_9th_key", key_o, 32'h28);
    check("cr_refill", outstanding_o, 8);
    resp_done_i = 1'b1;
    repeat (9) tick();
    resp_done_i = 1'b0;
    tick();
    check("cr_drain", outstanding_o, 0);
    check("cr_idle", idle_o, 1);
    check("cr_no_error", error_o, 0);

    // Simultaneous issue and response at 3, then underflow
    for (int i = 0; i < 3; i++) send(2'b01, 32'h30 + i, 32'h300 + i);
    tick(); tick();
    check("sim_outstanding3", outstanding_o, 3);
    stall_i = 1'b1;
    send(2'b10, 32'h33, 32'h77);
    stall_i = 1'b0; resp_done_i = 1'b1;
    tick();
    check("sim_issue_op", delete_write_read_o, 2'b10);
    check("sim_stays3", outstanding_o, 3);
    repeat (3) tick();
    check("sim_drained", outstanding_o, 0);
    check("sim_no_error_yet", error_o, 0);
    tick();
    check("uf_error", error_o, 1);
    check("uf_count0", outstanding_o, 0);
    resp_done_i = 1'b0;
    tick(); tick();
    check("uf_error_sticky", error_o, 1);
    check("uf_count_hold", outstanding_o, 0);

    // No-op request is accepted but never issued
    req_valid_i = 1'b1; req_op_i = 2'b00; req_key_i = 32'h99; req_data_i = 32'h1;
    check("nop_ready", req_ready_o, 1);
    tick();
    req_valid_i = 1'b0;
    tick();
    check("nop_idle", idle_o, 1);
    check("nop_op", delete_write_read_o, 0);

    // Reset mid-operation: 2 in flight, 3 buffered
    send(2'b01, 32'h40, 32'h400);
    send(2'b01, 32'h41, 32'h401);
    tick(); tick();
    check("mid_outstanding2", outstanding_o, 2);
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) send(2'b11, 32'h50 + i, 32'h0);
    check("mid_buffered_ready", req_ready_o, 1);
    check("mid_not_idle", idle_o, 0);
    exp_q.delete();
    reset_i = 1'b1; stall_i = 1'b0;
    req_valid_i = 1'b1; req_op_i = 2'b10; req_key_i = 32'hEE; req_data_i = 32'hEE;
    tick();
    reset_i = 1'b0; req_valid_i = 1'b0;
    check("mr_ready", req_ready_o, 1);
    check("mr_idle", idle_o, 1);
    check("mr_outstanding", outstanding_o, 0);
    check("mr_op", delete_write_read_o, 0);
    check("mr_key", key_o, 0);
    check("mr_data", data_o, 0);
    check("mr_error", error_o, 0);
    repeat (3) tick();
    check("mr_no_enqueue_idle", idle_o, 1);
    check("mr_no_enqueue_op", delete_write_read_o, 0);

    check("sb_drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
